// File: rtl/mem_port_master_if.sv
// Bundles the core request/response channels and the memory port of mem_port_master.
// master: the port initiator (mem_port_master). slave: the core plus memory side.
interface mem_port_master_if #(
    parameter int unsigned ADDR = 16,
    parameter int unsigned WORD = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [ADDR-1:0] req_addr;
    logic [WORD-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [WORD-1:0] rsp_rdata;

    logic [ADDR-1:0] mem_a;
    logic            mem_w;
    logic [WORD-1:0] mem_d;
    logic [WORD-1:0] mem_q;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_rdata, mem_a, mem_w, mem_d
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, mem_a, mem_w, mem_d
    );

endinterface

// File: rtl/mem_port_master.sv
// Initiator for a single-port synchronous memory with a 1-cycle registered read.
// Loads are captured into an in-order response FIFO; credits stop new requests
// before the FIFO could overflow, so the capture cycle never has to stall.
module mem_port_master #(
    parameter int unsigned ADDR  = 16,
    parameter int unsigned WORD  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    mem_port_master_if.master bus
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    logic            accept;
    logic            push;
    logic            pop;
    logic            rd_pending_q, rd_pending_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [SumW-1:0] credits_used;
    logic [WORD-1:0] fifo_q [DEPTH];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // A load in flight still owns a FIFO slot; a pop this cycle frees one early.
    assign pop          = (count_q != '0) & bus.rsp_ready;
    assign credits_used = {1'b0, count_q} + SumW'(rd_pending_q) - SumW'(pop);
    // Gating with rst keeps req_ready (and so mem_w) low throughout reset.
    assign bus.req_ready = rst & (credits_used < SumW'(DEPTH));
    assign accept        = bus.req_valid & bus.req_ready;

    assign bus.mem_a = bus.req_addr;
    assign bus.mem_d = bus.req_wdata;
    assign bus.mem_w = accept & bus.req_we;

    // mem_q is only valid in the cycle right after the load was issued.
    assign push = rd_pending_q;

    assign bus.rsp_valid = (count_q != '0);
    assign bus.rsp_rdata = fifo_q[rd_ptr_q];

    // Next-state for the pending flag, pointers and occupancy.
    always_comb begin
        rd_pending_d = accept & ~bus.req_we;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CntW'(push) - CntW'(pop);
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // Control state; reset discards any in-flight load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pending_q <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Response storage; cleared on reset so rsp_rdata reads zero while idle after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= bus.mem_q;
        end
    end

endmodule

// File: tb/tb_mem_port_master.sv
// Self-checking bench for mem_port_master: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level model (shadow memory
// plus a queue of outstanding load results tagged with their issue cycle).
module tb_mem_port_master;

    localparam int unsigned ADDR     = 16;
    localparam int unsigned WORD     = 32;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned MemWords = 256;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_master_if #(.ADDR(ADDR), .WORD(WORD)) bus ();

    mem_port_master #(.ADDR(ADDR), .WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // Memory model: write on mem_w, otherwise registered read every cycle.
    logic [31:0] mem [MemWords];
    logic        mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < int'(MemWords); i++) mem[i] <= init_word(i);
            mem_init_done <= 1'b1;
        end else if (bus.mem_w) begin
            mem[8'(bus.mem_a)] <= bus.mem_d;
        end else begin
            bus.mem_q <= mem[8'(bus.mem_a)];
        end
    end

    // Reference model.
    typedef struct {
        logic [31:0] data;
        int          issued;
    } exp_t;

    logic [31:0] ref_mem [MemWords];
    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check against the model, update the model, advance.
    task automatic cycle(input logic v, input logic we, input logic [15:0] a,
                         input logic [31:0] d, input logic rr);
        logic exp_valid, exp_ready, pop_now, acc;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        // A load issued in cycle N becomes visible in cycle N+2.
        exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].issued + 2);
        pop_now   = exp_valid && rr;
        // Outstanding loads (in flight or buffered) may never exceed DEPTH.
        exp_ready = (exp_q.size() - (pop_now ? 1 : 0)) < int'(DEPTH);
        acc       = v && exp_ready;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        if (exp_valid) chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("mem_w", 32'(bus.mem_w), 32'(acc && we));
        if (v) chk("mem_a", 32'(bus.mem_a), 32'(a));
        if (acc && we) chk("mem_d", bus.mem_d, d);
        if (pop_now) void'(exp_q.pop_front());
        if (acc) begin
            if (we) ref_mem[8'(a)] = d;
            else exp_q.push_back('{data: ref_mem[8'(a)], issued: cyc});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0, rr);
    endtask

    initial begin
        for (int i = 0; i < int'(MemWords); i++) ref_mem[i] = init_word(i);
        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0001;
        bus.req_wdata = 32'h1234_5678;
        bus.rsp_ready = 1'b1;
        #2;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_mem_w", 32'(bus.mem_w), 32'd0);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Store then load, 2-cycle latency, no response for the store.
        cycle(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b1, 1'b0, 16'h0010, 32'h0, 1'b1);
        idle(3, 1'b1);

        // Back-to-back loads at full rate.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 16'(i), 32'h100 + 32'(i), 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'(i), 32'h0, 1'b1);
        idle(3, 1'b1);

        // Backpressure: credits run out after DEPTH loads, then drain in order.
        cycle(1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0021, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0022, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'h0022, 32'h0, 1'b1);
        idle(4, 1'b1);

        // Store right after a load to the same address returns old then new data.
        cycle(1'b1, 1'b1, 16'h0030, 32'h11, 1'b1);
        cycle(1'b1, 1'b0, 16'h0030, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h0030, 32'h22, 1'b1);
        cycle(1'b1, 1'b0, 16'h0030, 32'h0, 1'b1);
        idle(4, 1'b1);

        // Asynchronous reset one cycle after a load accept drops the load.
        cycle(1'b1, 1'b0, 16'h0005, 32'h0, 1'b1);
        rst           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0041;
        bus.req_wdata = 32'hBAD0_BAD0;
        #1;
        chk("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_req_ready", 32'(bus.req_ready), 32'd0);
        chk("async_mem_w", 32'(bus.mem_w), 32'd0);
        chk("async_rsp_rdata", bus.rsp_rdata, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        #1;
        chk("rerelease_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rerelease_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        idle(3, 1'b1);
        cycle(1'b1, 1'b0, 16'h0005, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 16'h0041, 32'h0, 1'b1);
        idle(4, 1'b1);

        // Random mixed traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3) != 0);
        end
        idle(6, 1'b1);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
